// File: rtl/dpi_stream_sequencer.sv
// Front-end sequencer for a bank of per-stream regex matchers. It restores stream
// state, forwards packet bytes, and finalizes each packet after the matcher pipeline drains.
module dpi_stream_sequencer #(
    parameter int NUM_REGEX = 8,
    parameter int LOAD_LAT  = 2,
    parameter int DRAIN_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [5:0]           in_stream_id,
    input  logic                 cfg_wr,
    input  logic                 cfg_clr,
    input  logic [5:0]           cfg_stream_id,
    input  logic [NUM_REGEX-1:0] cfg_mask,
    output logic                 load_state,
    output logic [5:0]           stream_id,
    output logic                 new_stream_id,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    output logic [NUM_REGEX-1:0] enable,
    output logic                 busy,
    output logic                 pkt_done,
    output logic [15:0]          pkt_count,
    output logic [15:0]          err_count
);

    localparam int MAX_LAT = (LOAD_LAT > DRAIN_LAT) ? LOAD_LAT : DRAIN_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_STREAM, S_DRAIN, S_FIN
    } state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [5:0]                   sid_q, sid_d;
    logic [NUM_REGEX-1:0]         en_q, en_d;
    logic [63:0]                  valid_q, valid_d;
    logic [63:0][NUM_REGEX-1:0]   mask_q, mask_d;
    logic [15:0]                  pkt_q, pkt_d;
    logic [15:0]                  err_q, err_d;

    logic in_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sid_q   <= '0;
            en_q    <= '0;
            valid_q <= '0;
            mask_q  <= '1;
            pkt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sid_q   <= sid_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sid_d         = sid_q;
        en_d          = en_q;
        valid_d       = valid_q;
        mask_d        = mask_q;
        pkt_d         = pkt_q;
        err_d         = err_q;
        in_ready_c    = 1'b0;
        load_state    = 1'b0;
        new_stream_id = 1'b0;
        char_in       = '0;
        char_in_vld   = 1'b0;
        eop           = 1'b0;
        stream_id     = '0;
        enable        = '0;
        busy          = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (in_vld) begin
                    if (in_sop) begin
                        // SOP byte is left pending; it is consumed once STREAM opens.
                        sid_d   = in_stream_id;
                        state_d = S_LOAD;
                    end else begin
                        in_ready_c = 1'b1;
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    end
                end
            end
            S_LOAD: begin
                load_state    = 1'b1;
                stream_id     = sid_q;
                new_stream_id = ~valid_q[sid_q];
                enable        = mask_q[sid_q];
                en_d          = mask_q[sid_q];
                if (LOAD_LAT > 1) begin
                    cnt_d   = CW'(LOAD_LAT - 1);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_WAIT: begin
                stream_id = sid_q;
                enable    = en_q;
                if (cnt_q <= CW'(1)) state_d = S_STREAM;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            S_STREAM: begin
                stream_id   = sid_q;
                enable      = en_q;
                in_ready_c  = 1'b1;
                char_in     = in_data;
                char_in_vld = in_vld;
                if (in_vld && in_eop) begin
                    if (DRAIN_LAT > 1) begin
                        cnt_d   = CW'(DRAIN_LAT - 1);
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_DRAIN: begin
                stream_id = sid_q;
                enable    = en_q;
                if (cnt_q <= CW'(1)) state_d = S_FIN;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            S_FIN: begin
                stream_id = sid_q;
                enable    = en_q;
                eop       = 1'b1;
                pkt_d     = pkt_q + 16'd1;
                // A stream with every matcher disabled has produced no state worth restoring.
                if (en_q != '0) valid_d[sid_q] = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Applied after FIN so a same-cycle invalidate overrides the set.
        if (cfg_wr)  mask_d[cfg_stream_id]  = cfg_mask;
        if (cfg_clr) valid_d[cfg_stream_id] = 1'b0;
    end

    assign in_ready  = in_ready_c & ~rst;
    assign pkt_done  = eop;
    assign pkt_count = pkt_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Randomized scoreboard bench for dpi_stream_sequencer: the driver predicts load/byte/finalize
// events from a per-stream model; a negedge monitor pops and compares them as the DUT emits them.
module tb_dpi_stream_sequencer;
    localparam int NR = 8;
    localparam int LL = 2;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld, in_ready, in_sop, in_eop;
    logic [7:0]    in_data;
    logic [5:0]    in_stream_id;
    logic          cfg_wr, cfg_clr;
    logic [5:0]    cfg_stream_id;
    logic [NR-1:0] cfg_mask;
    logic          load_state, new_stream_id, char_in_vld, eop, busy, pkt_done;
    logic [5:0]    stream_id;
    logic [7:0]    char_in;
    logic [NR-1:0] enable;
    logic [15:0]   pkt_count, err_count;

    dpi_stream_sequencer #(.NUM_REGEX(NR), .LOAD_LAT(LL), .DRAIN_LAT(DL)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_stream_id(in_stream_id),
        .cfg_wr(cfg_wr), .cfg_clr(cfg_clr), .cfg_stream_id(cfg_stream_id), .cfg_mask(cfg_mask),
        .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
        .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop), .enable(enable),
        .busy(busy), .pkt_done(pkt_done), .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int sid; logic nw; logic [NR-1:0] en; } load_t;
    typedef struct { logic [7:0] data; int gap; int sid; logic [NR-1:0] en; } byte_t;
    typedef struct { int sid; logic [NR-1:0] en; logic [15:0] cnt; } fin_t;

    load_t load_q[$];
    byte_t byte_q[$];
    fin_t  fin_q[$];

    int checks = 0;
    int failures = 0;

    // reference state
    bit            mvalid [64];
    logic [NR-1:0] mmask  [64];
    int            mpkt, merr;
    int            fins_issued, fins_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 1'b0;
            mmask[i]  = '1;
        end
        mpkt = 0;
        merr = 0;
        fins_issued = 0;
        fins_seen = 0;
    endtask

    // ---------------- monitor ----------------
    int          load_cyc, last_cyc;
    logic        after_eop = 1'b0;
    logic [15:0] exp_pkt;

    always @(negedge clk) begin : monitor
        load_t l;
        byte_t b;
        fin_t  f;
        if (rst) begin
            after_eop = 1'b0;
        end else begin
            if (after_eop) begin
                chk("busy_after_eop", busy, 0);
                chk("pkt_count", pkt_count, exp_pkt);
                after_eop = 1'b0;
            end
            if (load_state) begin
                if (load_q.size() == 0) fail_now("unexpected_load_state");
                else begin
                    l = load_q.pop_front();
                    chk("load_stream_id", stream_id, l.sid);
                    chk("load_new_stream_id", new_stream_id, l.nw);
                    chk("load_enable", enable, l.en);
                end
                load_cyc = cyc;
            end
            if (char_in_vld) begin
                if (byte_q.size() == 0) fail_now("unexpected_char_in_vld");
                else begin
                    b = byte_q.pop_front();
                    chk("char_in", char_in, b.data);
                    if (b.gap < 0) chk("load_to_first_byte", cyc - load_cyc, LL);
                    else           chk("byte_spacing", cyc - last_cyc, b.gap + 1);
                    chk("byte_stream_id", stream_id, b.sid);
                    chk("byte_enable", enable, b.en);
                end
                last_cyc = cyc;
            end
            if (eop) begin
                if (fin_q.size() == 0) fail_now("unexpected_eop");
                else begin
                    f = fin_q.pop_front();
                    chk("pkt_done", pkt_done, 1);
                    chk("last_byte_to_eop", cyc - last_cyc, DL);
                    chk("eop_stream_id", stream_id, f.sid);
                    chk("eop_enable", enable, f.en);
                    exp_pkt   = f.cnt;
                    after_eop = 1'b1;
                end
                fins_seen++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                $display("FAIL handshake_timeout (cycle %0d)", cyc);
                $fatal(1, "handshake timeout");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input int i, input int len, input int sid, input logic [7:0] d);
        in_vld       = 1'b1;
        in_data      = d;
        in_sop       = (i == 0) ? 1'b1 : 1'($urandom);
        in_eop       = (i == len - 1);
        in_stream_id = (i == 0) ? 6'(sid) : 6'($urandom);
        wait_accept();
    endtask

    task automatic send_pkt(input int sid, input int len, input int maxgap, input int bubble_at);
        logic [NR-1:0] en;
        int            gaps[$];
        logic [7:0]    data[$];
        byte_t         b;
        int            n;
        en = mmask[sid];
        load_q.push_back('{sid, !mvalid[sid], en});
        for (int i = 0; i < len; i++) begin
            gaps.push_back((i == 0) ? -1 : (i == bubble_at) ? 3 : int'($urandom_range(0, maxgap)));
            data.push_back(8'($urandom));
            b = '{data[i], gaps[i], sid, en};
            byte_q.push_back(b);
        end
        mpkt = (mpkt + 1) & 16'hFFFF;
        fin_q.push_back('{sid, en, 16'(mpkt)});
        if (en != '0) mvalid[sid] = 1'b1;
        fins_issued++;
        for (int i = 0; i < len; i++) begin
            if (i > 0 && gaps[i] > 0) begin
                in_vld = 1'b0;
                repeat (gaps[i]) tick();
            end
            drive_byte(i, len, sid, data[i]);
        end
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        n = 0;
        while (fins_seen < fins_issued) begin
            tick();
            n++;
            if (n > 100) begin
                $display("FAIL eop_timeout (cycle %0d)", cyc);
                $fatal(1, "eop timeout");
            end
        end
        tick();
    endtask

    task automatic cfg_op(input logic wr, input logic clr, input int sid, input logic [NR-1:0] m);
        cfg_wr = wr; cfg_clr = clr; cfg_stream_id = 6'(sid); cfg_mask = m;
        tick();
        cfg_wr = 1'b0; cfg_clr = 1'b0;
        if (wr)  mmask[sid]  = m;
        if (clr) mvalid[sid] = 1'b0;
    endtask

    task automatic orphan();
        in_vld = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'($urandom);
        tick();
        in_vld = 1'b0;
        if (merr < 16'hFFFF) merr++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_ctrl"}, {load_state, new_stream_id, char_in_vld, eop, pkt_done}, 0);
        chk({tag, "_sid_en_char"}, {stream_id, enable, char_in}, 0);
        chk({tag, "_counters"}, {pkt_count, err_count}, 0);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    int sids[6] = '{5, 9, 12, 20, 33, 63};

    initial begin : driver
        byte_t b;
        in_vld = 0; in_sop = 0; in_eop = 0; in_data = 0; in_stream_id = 0;
        cfg_wr = 0; cfg_clr = 0; cfg_stream_id = 0; cfg_mask = 0;
        model_reset();
        rst = 1'b1;
        #1;
        in_vld = 1'b1;   // orphan-looking input must not raise in_ready under reset
        #1;
        check_all_zero("reset");
        in_vld = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        send_pkt(5, 3, 0, -1);            // never-seen stream, no gaps
        send_pkt(5, 2, 0, -1);            // now has saved state
        cfg_op(1'b0, 1'b1, 5, '0);
        send_pkt(5, 4, 0, -1);            // invalidated again
        cfg_op(1'b1, 1'b0, 9, 8'h00);
        send_pkt(9, 3, 0, -1);            // all matchers disabled
        send_pkt(9, 2, 0, -1);            // no state saved from previous
        send_pkt(12, 1, 0, -1);           // single byte packet
        orphan();
        orphan();
        chk("err_count_orphans", err_count, merr);
        send_pkt(20, 3, 0, -1);
        send_pkt(33, 6, 0, 3);            // 3-cycle bubble before byte 3

        for (int k = 0; k < 25; k++) begin
            int s;
            s = sids[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0)
                cfg_op(1'($urandom), 1'($urandom), sids[$urandom_range(0, 5)],
                       ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            if ($urandom_range(0, 5) == 0) orphan();
            send_pkt(s, $urandom_range(1, 6), 3, -1);
        end
        chk("err_count_random", err_count, merr);

        // Make sid 5 definitely valid, then reset mid-packet.
        cfg_op(1'b1, 1'b0, 5, 8'hA5);
        send_pkt(5, 2, 0, -1);
        load_q.push_back('{5, !mvalid[5], mmask[5]});
        b = '{8'h11, -1, 5, mmask[5]}; byte_q.push_back(b);
        b = '{8'h22, 0, 5, mmask[5]};  byte_q.push_back(b);
        drive_byte(0, 4, 5, 8'h11);
        drive_byte(1, 4, 5, 8'h22);
        in_vld = 1'b1; in_data = 8'h33; in_sop = 1'b0; in_eop = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        chk("midreset_queues_drained", load_q.size() + byte_q.size(), 0);
        in_vld = 1'b0;
        load_q.delete(); byte_q.delete(); fin_q.delete();
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send_pkt(5, 3, 1, -1);            // saved state was forgotten by reset
        send_pkt(5, 1, 0, -1);

        repeat (3) tick();
        chk("end_queues_empty", load_q.size() + byte_q.size() + fin_q.size(), 0);
        chk("end_pkt_count", pkt_count, mpkt);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
